// File: rtl/bsg_manycore_pkg.sv
// Shared types for the manycore barrier sequencer: FSM states, router config
// struct and barrier direction indices.
package bsg_manycore_pkg;

  localparam int barrier_dirs_gp    = 7;
  localparam int barrier_lg_dirs_gp = 3;

  localparam int barrier_dir_p_gp  = 0;
  localparam int barrier_dir_w_gp  = 1;
  localparam int barrier_dir_e_gp  = 2;
  localparam int barrier_dir_n_gp  = 3;
  localparam int barrier_dir_s_gp  = 4;
  localparam int barrier_dir_rw_gp = 5;
  localparam int barrier_dir_re_gp = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } bsg_manycore_barrier_ctrl_state_e;

  typedef struct packed {
    logic [barrier_dirs_gp-1:0]    src_r;
    logic [barrier_lg_dirs_gp-1:0] dest_r;
  } bsg_manycore_barrier_cfg_s;

endpackage

// File: rtl/bsg_manycore_barrier_wait_counter.sv
// Clearable, saturating up-counter measuring how long a barrier has waited.
module bsg_manycore_barrier_wait_counter #(
  parameter int cycle_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clear_i,
  input  logic                     up_i,
  output logic [cycle_width_p-1:0] count_o
);

  logic [cycle_width_p-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (up_i && (r_count != '1)) begin
      r_count <= r_count + cycle_width_p'(1);
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/bsg_manycore_barrier_ctrl.sv
// Per-tile barrier sequencer: holds router config, toggles the sense bit on a
// join and reports completion with a wait count. Optional: BSG_MANYCORE_BARRIER_TIMEOUT_EN.
module bsg_manycore_barrier_ctrl
  import bsg_manycore_pkg::*;
#(
  parameter  int barrier_dirs_p     = barrier_dirs_gp,
  parameter  int cycle_width_p      = 16,
  parameter  int timeout_cycles_p   = 4096,
  localparam int barrier_lg_dirs_lp = ((barrier_dirs_p + 1) <= 1) ? 1 : $clog2(barrier_dirs_p + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          cfg_v_i,
  input  logic [barrier_dirs_p-1:0]     cfg_src_r_i,
  input  logic [barrier_lg_dirs_lp-1:0] cfg_dest_r_i,
  output logic                          cfg_ready_o,
  input  logic                          join_v_i,
  output logic                          join_ready_o,
  output logic                          done_v_o,
  input  logic                          done_yumi_i,
  output logic [cycle_width_p-1:0]      done_cycles_o,
  output logic                          busy_o,
  output logic                          barrier_data_o,
  input  logic                          barrier_data_i,
  output logic [barrier_dirs_p-1:0]     barrier_src_r_o,
  output logic [barrier_lg_dirs_lp-1:0] barrier_dest_r_o
`ifdef BSG_MANYCORE_BARRIER_TIMEOUT_EN
  ,
  output logic                          timeout_o
`endif
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_DONE = DONE;

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high; ready never depends on the same-port valid, config beats join.
  logic [1:0]                r_state;
  logic [1:0]                w_state_n;
  logic                      r_sense;
  bsg_manycore_barrier_cfg_s r_cfg;
  logic                      w_idle;
  logic                      w_in_wait;
  logic                      w_cfg_hs;
  logic                      w_join_hs;
  logic                      w_match;
  logic                      w_timeout;
  logic [cycle_width_p-1:0]  w_count;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_in_wait = (r_state == ST_WAIT);

  assign cfg_ready_o  = reset_n_i & w_idle;
  assign join_ready_o = reset_n_i & w_idle & ~cfg_v_i;
  assign w_cfg_hs     = cfg_v_i & cfg_ready_o;
  assign w_join_hs    = join_v_i & join_ready_o;
  assign w_match      = w_in_wait & (barrier_data_i == r_sense);

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: if (w_join_hs)             w_state_n = ST_WAIT;
      ST_WAIT: if (w_match || w_timeout)  w_state_n = ST_DONE;
      ST_DONE: if (done_yumi_i)           w_state_n = ST_IDLE;
      default:                            w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
      r_sense <= 1'b0;
      r_cfg   <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_join_hs) r_sense <= ~r_sense;
      if (w_cfg_hs)  r_cfg   <= '{src_r: cfg_src_r_i, dest_r: cfg_dest_r_i};
    end
  end

  // Counting every WAIT cycle, the value latched on the matching edge already
  // includes the cycle in which the match was seen.
  bsg_manycore_barrier_wait_counter #(
    .cycle_width_p(cycle_width_p)
  ) u_wait_counter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (w_join_hs),
    .up_i     (w_in_wait),
    .count_o  (w_count)
  );

`ifdef BSG_MANYCORE_BARRIER_TIMEOUT_EN
  logic r_timeout;

  assign w_timeout = w_in_wait & ~w_match & ((int'(w_count) + 1) >= timeout_cycles_p);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_timeout <= 1'b1;
    end else if ((r_state == ST_DONE) && done_yumi_i) begin
      r_timeout <= 1'b0;
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^timeout_cycles_p;
`endif

  assign done_v_o         = (r_state == ST_DONE);
  assign busy_o           = ~w_idle;
  assign done_cycles_o    = w_count;
  assign barrier_data_o   = r_sense;
  assign barrier_src_r_o  = r_cfg.src_r;
  assign barrier_dest_r_o = r_cfg.dest_r;

endmodule

// File: tb/tb_bsg_manycore_barrier_ctrl.sv
// Bench for bsg_manycore_barrier_ctrl: directed scenarios plus randomized
// barriers checked against a per-cycle behavioural model and a done-count queue.
module tb_bsg_manycore_barrier_ctrl;

  localparam int DIRS = 7;
  localparam int LG   = 3;
  localparam int CW   = 16;

  logic            clk = 1'b0;
  logic            reset_n_i = 1'b0;
  logic            cfg_v_i = 1'b0;
  logic [DIRS-1:0] cfg_src_r_i = '0;
  logic [LG-1:0]   cfg_dest_r_i = '0;
  logic            cfg_ready_o;
  logic            join_v_i = 1'b0;
  logic            join_ready_o;
  logic            done_v_o;
  logic            done_yumi_i = 1'b0;
  logic [CW-1:0]   done_cycles_o;
  logic            busy_o;
  logic            barrier_data_o;
  logic            barrier_data_i = 1'b0;
  logic [DIRS-1:0] barrier_src_r_o;
  logic [LG-1:0]   barrier_dest_r_o;
`ifdef BSG_MANYCORE_BARRIER_TIMEOUT_EN
  logic            timeout_o;
`endif

  bsg_manycore_barrier_ctrl dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n_i),
    .cfg_v_i         (cfg_v_i),
    .cfg_src_r_i     (cfg_src_r_i),
    .cfg_dest_r_i    (cfg_dest_r_i),
    .cfg_ready_o     (cfg_ready_o),
    .join_v_i        (join_v_i),
    .join_ready_o    (join_ready_o),
    .done_v_o        (done_v_o),
    .done_yumi_i     (done_yumi_i),
    .done_cycles_o   (done_cycles_o),
    .busy_o          (busy_o),
    .barrier_data_o  (barrier_data_o),
    .barrier_data_i  (barrier_data_i),
    .barrier_src_r_o (barrier_src_r_o),
    .barrier_dest_r_o(barrier_dest_r_o)
`ifdef BSG_MANYCORE_BARRIER_TIMEOUT_EN
    ,
    .timeout_o       (timeout_o)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [CW-1:0] exp_q[$];
  bit tb_sense = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_ok = 1'b0;
  bit            m_sense, m_waiting, m_done;
  logic [DIRS-1:0] m_src;
  logic [LG-1:0] m_dest;
  int            m_wait_n, m_cycles;

  always @(posedge clk) begin
    if (!reset_n_i) begin
      m_ok <= 1'b1; m_sense <= 1'b0; m_waiting <= 1'b0; m_done <= 1'b0;
      m_src <= '0; m_dest <= '0; m_wait_n <= 0; m_cycles <= 0;
    end else if (m_ok) begin
      if (m_done) begin
        if (done_yumi_i) m_done <= 1'b0;
      end else if (m_waiting) begin
        m_wait_n <= m_wait_n + 1;
        if (barrier_data_i == m_sense) begin
          m_waiting <= 1'b0;
          m_done    <= 1'b1;
          m_cycles  <= (m_wait_n + 1 > 65535) ? 65535 : m_wait_n + 1;
        end
      end else if (cfg_v_i) begin
        m_src  <= cfg_src_r_i;
        m_dest <= cfg_dest_r_i;
      end else if (join_v_i) begin
        m_sense   <= ~m_sense;
        m_waiting <= 1'b1;
        m_wait_n  <= 0;
      end
    end
  end

  // Compare process: every falling edge once the model has seen reset.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("cfg_ready",  cfg_ready_o,  reset_n_i && !m_waiting && !m_done);
      chk("join_ready", join_ready_o, reset_n_i && !m_waiting && !m_done && !cfg_v_i);
      chk("done_v",     done_v_o,     m_done);
      chk("busy",       busy_o,       m_waiting || m_done);
      chk("data_o",     barrier_data_o, m_sense);
      chk("src_r",      barrier_src_r_o, m_src);
      chk("dest_r",     barrier_dest_r_o, m_dest);
      if (m_done) chk("done_cycles", done_cycles_o, m_cycles);
`ifdef BSG_MANYCORE_BARRIER_TIMEOUT_EN
      chk("timeout", timeout_o, 1'b0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_cfg(input logic [DIRS-1:0] src, input logic [LG-1:0] dest);
    bit ok = 1'b0;
    cfg_v_i = 1'b1; cfg_src_r_i = src; cfg_dest_r_i = dest;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cfg_ready_o) ok = 1'b1;
      tick();
    end
    cfg_v_i = 1'b0;
    if (!ok) chk("cfg_accept_timeout", 0, 1);
  endtask

  task automatic start_join(output bit ok, output int tries);
    ok = 1'b0; tries = 0;
    join_v_i = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      tries++;
      if (join_ready_o) ok = 1'b1;
      tick();
    end
    join_v_i = 1'b0;
    if (!ok) chk("join_accept_timeout", 0, 1);
    else begin
      tb_sense = ~tb_sense;
      chk("data_after_join", barrier_data_o, tb_sense);
    end
  endtask

  // k mismatching WAIT cycles, then a match; done held for 'hold' cycles.
  task automatic run_barrier(input int k, input int hold, input bit poke, output int got, output int tries);
    bit ok;
    logic [CW-1:0] exp_c;
    got = -1;
    start_join(ok, tries);
    if (!ok) return;
    exp_q.push_back(CW'(k + 1));
    for (int i = 0; i < k; i++) begin
      barrier_data_i = ~tb_sense;
      if (poke) begin
        cfg_v_i      = 1'($urandom_range(0, 1));
        cfg_src_r_i  = DIRS'($urandom_range(0, 127));
        cfg_dest_r_i = LG'($urandom_range(0, 7));
        done_yumi_i  = 1'($urandom_range(0, 1));
      end
      tick();
    end
    barrier_data_i = tb_sense;
    cfg_v_i = 1'b0; done_yumi_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (done_v_o) ok = 1'b1;
    end
    if (!ok) begin
      chk("done_timeout", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    exp_c = exp_q.pop_front();
    got = int'(done_cycles_o);
    chk("sb_done_cycles", done_cycles_o, exp_c);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_join_ready", join_ready_o, 1'b0);
      chk("hold_cycles", done_cycles_o, exp_c);
    end
    done_yumi_i = 1'b1;
    tick();
    done_yumi_i = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset_n_i = 1'b0; cfg_v_i = 1'b0; join_v_i = 1'b0; done_yumi_i = 1'b0;
    repeat (n) tick();
    reset_n_i = 1'b1;
    tb_sense  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int got, tries;
    bit ok;
    logic [DIRS-1:0] src_before;

    // Reset held three cycles: everything quiet.
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready_o, 0);
    chk("rst_join_ready", join_ready_o, 0);
    chk("rst_done_v", done_v_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_data_o", barrier_data_o, 0);
    chk("rst_src", barrier_src_r_o, 0);
    chk("rst_dest", barrier_dest_r_o, 0);
    tick();
    reset_n_i = 1'b1;
    @(negedge clk);
    chk("idle_cfg_ready", cfg_ready_o, 1);
    chk("idle_join_ready", join_ready_o, 1);
    tick();

    // Config then a barrier whose echo arrives on the first WAIT cycle.
    do_cfg(7'b0000001, 3'd0);
    chk("cfg_src_applied", barrier_src_r_o, 7'b0000001);
    run_barrier(0, 0, 1'b0, got, tries);
    chk("tp2_cycles", got, 1);

    // Back-to-back: sense goes 1 then 0; stale 1 must not finish the second.
    chk("sense_after_first", barrier_data_o, 1);
    run_barrier(3, 0, 1'b0, got, tries);
    chk("sense_after_second", barrier_data_o, 0);
    chk("tp3_cycles", got, 4);

    // Contention: config wins, join taken next cycle.
    cfg_v_i = 1'b1; cfg_src_r_i = 7'h55; cfg_dest_r_i = 3'd3; join_v_i = 1'b1;
    @(negedge clk);
    chk("contend_join_ready", join_ready_o, 0);
    chk("contend_cfg_ready", cfg_ready_o, 1);
    tick();
    cfg_v_i = 1'b0;
    src_before = 7'h55;
    run_barrier(6, 1, 1'b1, got, tries);
    chk("contend_join_tries", tries, 1);
    chk("wait_cfg_ignored", barrier_src_r_o, src_before);

    // Long mismatch and a held done.
    run_barrier(20, 5, 1'b0, got, tries);
    chk("tp5_cycles", got, 21);

    // Abort mid-WAIT via reset.
    start_join(ok, tries);
    barrier_data_i = ~tb_sense;
    repeat (3) tick();
    reset_n_i = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("abort_data_o", barrier_data_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done_v", done_v_o, 0);
    tick();
    reset_n_i = 1'b1;
    tb_sense  = 1'b0;
    barrier_data_i = 1'b0;
    tick();

    // Randomized barriers with config writes in between.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_cfg(DIRS'($urandom_range(0, 127)), LG'($urandom_range(0, 7)));
      run_barrier($urandom_range(0, 25), $urandom_range(0, 4), 1'b1, got, tries);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
